// File: rtl/hazard_if.sv
// Decode-side view of the hazard controller: ID operand/destination info in,
// forwarding selects, stall, flush and the stall counter out.
interface hazard_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned SEL_W  = 2,
  parameter int unsigned CNT_W  = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_rs_used;
  logic              id_rt_used;
  logic [REG_AW-1:0] id_dst;
  logic              id_wr;
  logic              id_load;
  logic              redirect;
  logic [SEL_W-1:0]  fwd_sel_a;
  logic [SEL_W-1:0]  fwd_sel_b;
  logic              stall;
  logic              flush;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_dst, id_wr, id_load, redirect,
    input  fwd_sel_a, fwd_sel_b, stall, flush, stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_dst, id_wr, id_load, redirect,
    output fwd_sel_a, fwd_sel_b, stall, flush, stall_count
  );
endinterface

// File: rtl/hazard_unit.sv
// Forwarding, load-use stall and redirect-flush controller for the MIPS pipeline.
// Tracks the last FWD_DEPTH issued destinations in a never-stalling shadow pipeline.
module hazard_unit #(
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned FWD_DEPTH    = 2,
  parameter int unsigned LOAD_READY   = 2,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned SEL_W        = $clog2(FWD_DEPTH + 1)
) (
  input  logic     clk,
  input  logic     rst,
  hazard_if.slave  bus
);

  localparam int unsigned FcntW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  // Index 0 is stage 1 (execute).
  logic [FWD_DEPTH-1:0] v_q;
  logic [FWD_DEPTH-1:0] wr_q;
  logic [FWD_DEPTH-1:0] ld_q;
  logic [REG_AW-1:0]    dst_q [FWD_DEPTH];

  logic [FcntW-1:0]     fcnt_q;
  logic [CNT_W-1:0]     cnt_q;

  logic [SEL_W-1:0]     sel_a;
  logic [SEL_W-1:0]     sel_b;
  logic                 haz_a;
  logic                 haz_b;
  logic                 flush;
  logic                 stall;
  logic                 issue;

  // Walk oldest to youngest so the youngest matching producer wins.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    haz_a = 1'b0;
    haz_b = 1'b0;
    for (int k = int'(FWD_DEPTH) - 1; k >= 0; k--) begin
      if (v_q[k] && wr_q[k] && (dst_q[k] == bus.id_rs) && (bus.id_rs != '0) &&
          bus.id_rs_used) begin
        sel_a = SEL_W'(k + 1);
        haz_a = ld_q[k] && ((k + 1) < int'(LOAD_READY));
      end
      if (v_q[k] && wr_q[k] && (dst_q[k] == bus.id_rt) && (bus.id_rt != '0) &&
          bus.id_rt_used) begin
        sel_b = SEL_W'(k + 1);
        haz_b = ld_q[k] && ((k + 1) < int'(LOAD_READY));
      end
    end
  end

  always_comb begin
    flush = bus.redirect || (fcnt_q != '0);
    stall = bus.id_valid && (haz_a || haz_b) && !flush;
    issue = bus.id_valid && !stall && !flush;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q    <= '0;
      wr_q   <= '0;
      ld_q   <= '0;
      for (int k = 0; k < int'(FWD_DEPTH); k++) begin
        dst_q[k] <= '0;
      end
      fcnt_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int k = int'(FWD_DEPTH) - 1; k > 0; k--) begin
        v_q[k]   <= v_q[k-1];
        wr_q[k]  <= wr_q[k-1];
        ld_q[k]  <= ld_q[k-1];
        dst_q[k] <= dst_q[k-1];
      end
      v_q[0]   <= issue;
      wr_q[0]  <= bus.id_wr;
      ld_q[0]  <= bus.id_load;
      dst_q[0] <= bus.id_dst;

      // A redirect reloads the counter, so back-to-back redirects extend the flush.
      if (bus.redirect) begin
        fcnt_q <= FcntW'(FLUSH_CYCLES - 1);
      end else if (fcnt_q != '0) begin
        fcnt_q <= fcnt_q - 1'b1;
      end

      if (stall && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.fwd_sel_a   = sel_a;
  assign bus.fwd_sel_b   = sel_b;
  assign bus.stall       = stall;
  assign bus.flush       = flush;
  assign bus.stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: two parameterisations, expected responses queued by the
// stimulus and compared by an independent monitor.
module tb_hazard_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // A: defaults except a 2-cycle flush and a 4-bit counter. B: load ready only from the RF.
  hazard_if #(.REG_AW(5), .SEL_W(2), .CNT_W(4))  hif_a ();
  hazard_if #(.REG_AW(5), .SEL_W(2), .CNT_W(16)) hif_b ();

  hazard_unit #(
    .REG_AW(5), .FWD_DEPTH(2), .LOAD_READY(2), .FLUSH_CYCLES(2), .CNT_W(4)
  ) dut_a (
    .clk(clk),
    .rst(rst),
    .bus(hif_a.slave)
  );

  hazard_unit #(
    .REG_AW(5), .FWD_DEPTH(2), .LOAD_READY(3), .FLUSH_CYCLES(1), .CNT_W(16)
  ) dut_b (
    .clk(clk),
    .rst(rst),
    .bus(hif_b.slave)
  );

  typedef struct {
    int    which;
    string name;
    int    sa;
    int    sb;
    int    st;
    int    fl;
    int    cnt;
  } exp_t;

  exp_t sb_q[$];
  event async_ev;

  // -1 in any expected field means don't-care.
  task automatic expect_out(input int which, input string name, input int sa, input int sb,
                            input int st, input int fl, input int cnt);
    exp_t e;
    e.which = which; e.name = name;
    e.sa = sa; e.sb = sb; e.st = st; e.fl = fl; e.cnt = cnt;
    sb_q.push_back(e);
  endtask

  task automatic check(input exp_t e);
    int sa, sb, st, fl, cnt;
    if (e.which == 0) begin
      sa = int'(hif_a.fwd_sel_a); sb = int'(hif_a.fwd_sel_b);
      st = int'(hif_a.stall);     fl = int'(hif_a.flush);
      cnt = int'(hif_a.stall_count);
    end else begin
      sa = int'(hif_b.fwd_sel_a); sb = int'(hif_b.fwd_sel_b);
      st = int'(hif_b.stall);     fl = int'(hif_b.flush);
      cnt = int'(hif_b.stall_count);
    end
    n_cmp++;
    if ((e.sa >= 0 && sa != e.sa) || (e.sb >= 0 && sb != e.sb) ||
        (e.st >= 0 && st != e.st) || (e.fl >= 0 && fl != e.fl) ||
        (e.cnt >= 0 && cnt != e.cnt)) begin
      n_bad++;
      $display("FAIL %s (dut %0d): got sel_a=%0d sel_b=%0d stall=%0d flush=%0d cnt=%0d; want %0d %0d %0d %0d %0d",
               e.name, e.which, sa, sb, st, fl, cnt, e.sa, e.sb, e.st, e.fl, e.cnt);
    end
  endtask

  // Monitor: outputs are sampled mid-cycle, or on demand around asynchronous reset.
  initial begin
    forever begin
      @(negedge clk or async_ev);
      while (sb_q.size() > 0) check(sb_q.pop_front());
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic valid, input logic [4:0] rs, input logic [4:0] rt,
                       input logic rsu, input logic rtu, input logic [4:0] dst,
                       input logic wr, input logic ld, input logic redir);
    hif_a.id_valid = valid; hif_b.id_valid = valid;
    hif_a.id_rs = rs;       hif_b.id_rs = rs;
    hif_a.id_rt = rt;       hif_b.id_rt = rt;
    hif_a.id_rs_used = rsu; hif_b.id_rs_used = rsu;
    hif_a.id_rt_used = rtu; hif_b.id_rt_used = rtu;
    hif_a.id_dst = dst;     hif_b.id_dst = dst;
    hif_a.id_wr = wr;       hif_b.id_wr = wr;
    hif_a.id_load = ld;     hif_b.id_load = ld;
    hif_a.redirect = redir; hif_b.redirect = redir;
  endtask

  task automatic idle(input logic redir);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, redir);
  endtask

  // lw $8 and the dependent addu $9, $8, $8
  task automatic lw8();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic use8();
    drive(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout; want run to complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    idle(1'b0);
    #3;
    expect_out(0, "reset_a", 0, 0, 0, 0, 0);
    expect_out(1, "reset_b", 0, 0, 0, 0, 0);
    -> async_ev;
    nxt();
    nxt();
    rst = 1'b1;

    // addu $5 then a reader of rs=$5: forward from stage 1
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    expect_out(0, "empty", 0, 0, 0, 0, 0);
    nxt(); drive(1'b1, 5'd5, 5'd3, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    expect_out(0, "fwd_s1", 1, 0, 0, 0, 0);
    nxt(); drive(1'b1, 5'd7, 5'd9, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
    expect_out(0, "indep", 0, 0, 0, 0, 0);
    // one instruction between producer $6 and reader: stage 2
    nxt(); drive(1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    expect_out(0, "fwd_s2", 2, 0, 0, 0, 0);
    nxt(); drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    expect_out(0, "no_match", 0, 0, 0, 0, 0);
    // $5 in stages 1 and 2; youngest wins. This one writes $0.
    nxt(); drive(1'b1, 5'd0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    expect_out(0, "youngest", 0, 1, 0, 0, 0);
    nxt(); drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    expect_out(0, "reg0", 0, 0, 0, 0, 0);

    // load-use, 1-cycle penalty
    nxt(); lw8();
    expect_out(0, "lw_issue", 0, 0, 0, 0, 0);
    nxt(); use8();
    expect_out(0, "lu_stall", -1, -1, 1, 0, 0);
    nxt(); use8();
    expect_out(0, "lu_fwd", 2, 2, 0, 0, 1);

    // lw $4, then its reader coincides with redirects: flush wins, no stall counted
    nxt(); drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0);
    expect_out(0, "lw4", 0, 0, 0, 0, 1);
    nxt(); drive(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 5'd11, 1'b1, 1'b0, 1'b1);
    expect_out(0, "flush_vs_stall", 1, 0, 0, 1, 1);
    nxt(); drive(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 5'd11, 1'b1, 1'b0, 1'b1);
    expect_out(0, "redirect2", 2, 0, 0, 1, 1);
    nxt(); drive(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0);
    expect_out(0, "flush_ext", 0, 0, 0, 1, 1);
    nxt(); idle(1'b0);
    expect_out(0, "flush_end", 0, 0, 0, 0, 1);

    // single redirect: exactly two flush cycles
    nxt(); idle(1'b1);
    expect_out(0, "flush_1", 0, 0, 0, 1, 1);
    nxt(); idle(1'b0);
    expect_out(0, "flush_2", 0, 0, 0, 1, 1);
    nxt(); idle(1'b0);
    expect_out(0, "flush_off", 0, 0, 0, 0, 1);

    // repeated load-use pairs drive the 4-bit counter into saturation
    c = 1;
    for (int i = 0; i < 16; i++) begin
      nxt(); lw8();
      expect_out(0, "sat_lw", 0, 0, 0, 0, c);
      nxt(); use8();
      expect_out(0, "sat_stall", -1, -1, 1, 0, c);
      c = (c < 15) ? c + 1 : 15;
      nxt(); use8();
      expect_out(0, "sat_fwd", 2, 2, 0, 0, c);
    end

    // asynchronous reset in the middle of a stall
    nxt(); lw8();
    expect_out(0, "pre_lw", 0, 0, 0, 0, 15);
    nxt(); use8();
    #1;
    expect_out(0, "pre_reset", -1, -1, 1, 0, 15);
    -> async_ev;
    #1;
    rst = 1'b0;
    #1;
    expect_out(0, "async_rst_a", 0, 0, 0, 0, 0);
    expect_out(1, "async_rst_b", 0, 0, 0, 0, 0);
    -> async_ev;
    nxt();
    rst = 1'b1;
    use8();
    expect_out(0, "post_reset_a", 0, 0, 0, 0, 0);
    expect_out(1, "post_reset_b", 0, 0, 0, 0, 0);

    // LOAD_READY = FWD_DEPTH+1: two stall cycles, then register file
    nxt(); lw8();
    expect_out(1, "b_lw", 0, 0, 0, 0, 0);
    nxt(); use8();
    expect_out(1, "b_stall1", -1, -1, 1, 0, 0);
    expect_out(0, "a_stall", -1, -1, 1, 0, 0);
    nxt(); use8();
    expect_out(1, "b_stall2", -1, -1, 1, 0, 1);
    expect_out(0, "a_fwd", 2, 2, 0, 0, 1);
    nxt(); use8();
    expect_out(1, "b_rf", 0, 0, 0, 0, 2);

    // FLUSH_CYCLES=1 on B versus 2 on A
    nxt(); idle(1'b1);
    expect_out(1, "b_flush", 0, 0, 0, 1, 2);
    expect_out(0, "a_flush", 0, 0, 0, 1, 1);
    nxt(); idle(1'b0);
    expect_out(1, "b_flush_off", 0, 0, 0, 0, 2);
    expect_out(0, "a_flush_on", 0, 0, 0, 1, 1);
    nxt(); idle(1'b0);
    expect_out(0, "a_flush_off", 0, 0, 0, 0, 1);

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d unchecked entries; want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
